// File: rtl/arb_burst_mux_if.sv
// Bundle of the requester, arbiter and output-stream signals of arb_burst_mux.
// The slave modport is the mux's view; master is the view of whatever surrounds it.
interface arb_burst_mux_if #(
   parameter int NUM = 4,
   parameter int DW  = 32
);
   localparam int SW = $clog2(NUM);

   logic [NUM-1:0]    req_valid_i;
   logic [NUM*DW-1:0] req_data_i;
   logic [NUM-1:0]    req_last_i;
   logic [NUM-1:0]    req_ready_o;
   logic [NUM-1:0]    arb_req_o;
   logic [NUM-1:0]    arb_gnt_i;
   logic              out_valid_o;
   logic [DW-1:0]     out_data_o;
   logic              out_last_o;
   logic [SW-1:0]     out_src_o;
   logic              out_ready_i;
   logic              busy_o;

   modport slave (
      input  req_valid_i, req_data_i, req_last_i, arb_gnt_i, out_ready_i,
      output req_ready_o, arb_req_o, out_valid_o, out_data_o, out_last_o, out_src_o, busy_o
   );

   modport master (
      output req_valid_i, req_data_i, req_last_i, arb_gnt_i, out_ready_i,
      input  req_ready_o, arb_req_o, out_valid_o, out_data_o, out_last_o, out_src_o, busy_o
   );
endinterface

// File: rtl/arb_burst_mux.sv
// Burst-locking mux behind a fixed-priority arbiter: holds the grant for a whole burst and
// forwards beats through one registered stream. Define ARB_BURST_LIMIT_EN to cap bursts at MAX_BEATS.
module arb_burst_mux #(
   parameter int NUM       = 4,
   parameter int DW        = 32,
   parameter int MAX_BEATS = 16
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   arb_burst_mux_if.slave bus
);
   localparam int SW = $clog2(NUM);

   generate
      if (NUM < 2 || MAX_BEATS < 1 || MAX_BEATS > 256) begin : g_param_check
         $error("arb_burst_mux: NUM must be >= 2 and MAX_BEATS within 1..256");
      end
   endgenerate

   typedef enum logic {IDLE, LOCK} state_t;

   state_t        state_reg;
   logic [SW-1:0] owner_reg;
   logic          out_valid_reg;
   logic [DW-1:0] out_data_reg;
   logic          out_last_reg;
   logic [SW-1:0] out_src_reg;

   logic [DW-1:0]  data_arr [NUM];
   logic [NUM-1:0] ready_vec;
   logic [SW-1:0]  gnt_idx;
   logic           out_free;
   logic           take;
   logic           limit_hit;
   logic           release_beat;

   // The output slot can accept a beat when empty or when its beat leaves this cycle.
   assign out_free = ~out_valid_reg | bus.out_ready_i;

   genvar gi;
   generate
      for (gi = 0; gi < NUM; gi++) begin : g_req
         assign data_arr[gi]  = bus.req_data_i[gi*DW +: DW];
         assign ready_vec[gi] = (state_reg == LOCK) && (owner_reg == SW'(gi))
                                && bus.req_valid_i[gi] && out_free;
      end
   endgenerate

   // A malformed multi-hot grant resolves to its lowest set index.
   always_comb begin
      gnt_idx = '0;
      for (int i = NUM - 1; i >= 0; i--) begin
         if (bus.arb_gnt_i[i]) gnt_idx = SW'(i);
      end
   end

   assign take         = |ready_vec;
   assign release_beat = bus.req_last_i[owner_reg] | limit_hit;

`ifdef ARB_BURST_LIMIT_EN
   logic [7:0] beat_cnt_reg;

   assign limit_hit = (beat_cnt_reg == 8'(MAX_BEATS - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beat_cnt_reg <= '0;
      end else if (state_reg == IDLE) begin
         beat_cnt_reg <= '0;
      end else if (take) begin
         beat_cnt_reg <= release_beat ? 8'd0 : beat_cnt_reg + 8'd1;
      end
   end
`else
   assign limit_hit = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= IDLE;
         owner_reg     <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_last_reg  <= 1'b0;
         out_src_reg   <= '0;
      end else begin
         if (take) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= data_arr[owner_reg];
            out_last_reg  <= release_beat;
            out_src_reg   <= owner_reg;
         end else if (out_valid_reg && bus.out_ready_i) begin
            out_valid_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (|bus.arb_gnt_i) begin
                  owner_reg <= gnt_idx;
                  state_reg <= LOCK;
               end
            end
            LOCK: begin
               if (take && release_beat) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Requests are hidden from the arbiter while a burst owns the output.
   assign bus.arb_req_o   = (state_reg == IDLE) ? bus.req_valid_i : '0;
   assign bus.req_ready_o = ready_vec;
   assign bus.out_valid_o = out_valid_reg;
   assign bus.out_data_o  = out_data_reg;
   assign bus.out_last_o  = out_last_reg;
   assign bus.out_src_o   = out_src_reg;
   assign bus.busy_o      = (state_reg == LOCK) | out_valid_reg;
endmodule

// File: tb/tb_arb_burst_mux.sv
// Directed bench for arb_burst_mux with a fixed-priority (index 0 highest) arbiter model.
// Build with ARB_BURST_LIMIT_EN defined to exercise the MAX_BEATS = 4 burst cap.
module tb_arb_burst_mux;
   localparam int NUM       = 4;
   localparam int DW        = 32;
   localparam int MAX_BEATS = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int tests_run    = 0;
   int tests_failed = 0;

   logic           gnt_force_en = 1'b0;
   logic [NUM-1:0] gnt_force    = '0;

   arb_burst_mux_if #(.NUM(NUM), .DW(DW)) bus ();

   arb_burst_mux #(.NUM(NUM), .DW(DW), .MAX_BEATS(MAX_BEATS)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   // Fixed-priority arbiter: isolate the lowest set request bit.
   assign bus.arb_gnt_i = gnt_force_en ? gnt_force
                                       : (bus.arb_req_o & (~bus.arb_req_o + NUM'(1)));

   task automatic set_beat(input int k, input logic [DW-1:0] d, input logic l);
      bus.req_valid_i[k]          = 1'b1;
      bus.req_data_i[k*DW +: DW]  = d;
      bus.req_last_i[k]           = l;
   endtask

   task automatic drop_req(input int k);
      bus.req_valid_i[k]          = 1'b0;
      bus.req_data_i[k*DW +: DW]  = '0;
      bus.req_last_i[k]           = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         bus.req_valid_i = NUM'($urandom);
         bus.req_data_i  = {$urandom, $urandom, $urandom, $urandom};
         bus.req_last_i  = NUM'($urandom);
         bus.out_ready_i = 1'($urandom);
         #1;
         tests_run++; if ({bus.out_valid_o, bus.out_data_o, bus.out_last_o, bus.out_src_o, bus.req_ready_o, bus.busy_o} !== '0) begin tests_failed++; $display("FAIL reset_outputs: got v=%b d=%h l=%b s=%0d r=%b busy=%b want all 0", bus.out_valid_o, bus.out_data_o, bus.out_last_o, bus.out_src_o, bus.req_ready_o, bus.busy_o); end
         tests_run++; if (bus.arb_req_o !== bus.req_valid_i) begin tests_failed++; $display("FAIL reset_arb_req: got %b want %b", bus.arb_req_o, bus.req_valid_i); end
      end
      @(negedge clk);
      bus.req_valid_i = '0; bus.req_data_i = '0; bus.req_last_i = '0; bus.out_ready_i = 1'b1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      tests_run++; if ({bus.busy_o, bus.out_valid_o, bus.arb_req_o, bus.req_ready_o} !== '0) begin tests_failed++; $display("FAIL reset_idle: got busy=%b v=%b arb=%b rdy=%b want all 0", bus.busy_o, bus.out_valid_o, bus.arb_req_o, bus.req_ready_o); end
   endtask

   task automatic test_single();
      @(negedge clk);
      bus.out_ready_i = 1'b1; set_beat(2, 32'hA0, 1'b0); #1;
      tests_run++; if ({bus.arb_req_o, bus.req_ready_o} !== 8'b0100_0000) begin tests_failed++; $display("FAIL single_req: got arb=%b rdy=%b want arb=0100 rdy=0000", bus.arb_req_o, bus.req_ready_o); end
      @(negedge clk); #1;
      tests_run++; if ({bus.out_valid_o, bus.req_ready_o} !== 5'b0_0100) begin tests_failed++; $display("FAIL single_ready: got v=%b rdy=%b want v=0 rdy=0100", bus.out_valid_o, bus.req_ready_o); end
      @(negedge clk);
      tests_run++; if ({bus.out_valid_o, bus.out_last_o, bus.out_src_o, bus.out_data_o} !== {1'b1, 1'b0, 2'd2, 32'hA0}) begin tests_failed++; $display("FAIL single_beat0: got v=%b l=%b s=%0d d=%h want 1 0 2 a0", bus.out_valid_o, bus.out_last_o, bus.out_src_o, bus.out_data_o); end
      $display("[TB] single beat src=%0d data=%h last=%b", bus.out_src_o, bus.out_data_o, bus.out_last_o);
      set_beat(2, 32'hA1, 1'b0);
      @(negedge clk);
      tests_run++; if ({bus.out_valid_o, bus.out_last_o, bus.out_src_o, bus.out_data_o} !== {1'b1, 1'b0, 2'd2, 32'hA1}) begin tests_failed++; $display("FAIL single_beat1: got v=%b l=%b s=%0d d=%h want 1 0 2 a1", bus.out_valid_o, bus.out_last_o, bus.out_src_o, bus.out_data_o); end
      $display("[TB] single beat src=%0d data=%h last=%b", bus.out_src_o, bus.out_data_o, bus.out_last_o);
      set_beat(2, 32'hA2, 1'b1);
      @(negedge clk);
      tests_run++; if ({bus.out_valid_o, bus.out_last_o, bus.out_src_o, bus.out_data_o} !== {1'b1, 1'b1, 2'd2, 32'hA2}) begin tests_failed++; $display("FAIL single_beat2: got v=%b l=%b s=%0d d=%h want 1 1 2 a2", bus.out_valid_o, bus.out_last_o, bus.out_src_o, bus.out_data_o); end
      $display("[TB] single beat src=%0d data=%h last=%b", bus.out_src_o, bus.out_data_o, bus.out_last_o);
      drop_req(2);
      @(negedge clk); #1;
      tests_run++; if ({bus.out_valid_o, bus.busy_o} !== 2'b00) begin tests_failed++; $display("FAIL single_drain: got v=%b busy=%b want 0 0", bus.out_valid_o, bus.busy_o); end
   endtask

   task automatic test_contention();
      @(negedge clk);
      bus.out_ready_i = 1'b1; set_beat(3, 32'hD0, 1'b0); #1;
      tests_run++; if (bus.arb_req_o !== 4'b1000) begin tests_failed++; $display("FAIL cont_req3: got %b want 1000", bus.arb_req_o); end
      @(negedge clk);
      set_beat(0, 32'hE0, 1'b1); #1;
      tests_run++; if ({bus.arb_req_o, bus.req_ready_o} !== 8'b0000_1000) begin tests_failed++; $display("FAIL cont_locked: got arb=%b rdy=%b want arb=0000 rdy=1000", bus.arb_req_o, bus.req_ready_o); end
      @(negedge clk);
      set_beat(3, 32'hD1, 1'b0); #1;
      tests_run++; if ({bus.arb_req_o, bus.out_data_o} !== {4'b0000, 32'hD0}) begin tests_failed++; $display("FAIL cont_beat0: got arb=%b d=%h want arb=0000 d=d0", bus.arb_req_o, bus.out_data_o); end
      @(negedge clk);
      set_beat(3, 32'hD2, 1'b1); #1;
      tests_run++; if ({bus.arb_req_o, bus.out_data_o} !== {4'b0000, 32'hD1}) begin tests_failed++; $display("FAIL cont_beat1: got arb=%b d=%h want arb=0000 d=d1", bus.arb_req_o, bus.out_data_o); end
      @(negedge clk);
      tests_run++; if ({bus.out_last_o, bus.out_src_o, bus.out_data_o} !== {1'b1, 2'd3, 32'hD2}) begin tests_failed++; $display("FAIL cont_last: got l=%b s=%0d d=%h want 1 3 d2", bus.out_last_o, bus.out_src_o, bus.out_data_o); end
      drop_req(3); #1;
      tests_run++; if ({bus.arb_req_o, bus.req_ready_o} !== 8'b0001_0000) begin tests_failed++; $display("FAIL cont_bubble: got arb=%b rdy=%b want arb=0001 rdy=0000", bus.arb_req_o, bus.req_ready_o); end
      @(negedge clk); #1;
      tests_run++; if ({bus.out_valid_o, bus.req_ready_o} !== 5'b0_0001) begin tests_failed++; $display("FAIL cont_grant0: got v=%b rdy=%b want v=0 rdy=0001", bus.out_valid_o, bus.req_ready_o); end
      @(negedge clk);
      tests_run++; if ({bus.out_valid_o, bus.out_last_o, bus.out_src_o, bus.out_data_o} !== {1'b1, 1'b1, 2'd0, 32'hE0}) begin tests_failed++; $display("FAIL cont_beat_r0: got v=%b l=%b s=%0d d=%h want 1 1 0 e0", bus.out_valid_o, bus.out_last_o, bus.out_src_o, bus.out_data_o); end
      $display("[TB] contention beat src=%0d data=%h last=%b", bus.out_src_o, bus.out_data_o, bus.out_last_o);
      drop_req(0);
      @(negedge clk); #1;
      tests_run++; if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL cont_idle: got busy=%b want 0", bus.busy_o); end
   endtask

   task automatic test_multi_grant();
      @(negedge clk);
      bus.out_ready_i = 1'b1;
      set_beat(1, 32'h11, 1'b1); set_beat(3, 32'h33, 1'b0);
      gnt_force = 4'b1010; gnt_force_en = 1'b1;
      @(negedge clk);
      gnt_force_en = 1'b0; #1;
      tests_run++; if (bus.req_ready_o !== 4'b0010) begin tests_failed++; $display("FAIL multi_grant_owner: got rdy=%b want 0010", bus.req_ready_o); end
      @(negedge clk);
      tests_run++; if ({bus.out_valid_o, bus.out_last_o, bus.out_src_o, bus.out_data_o} !== {1'b1, 1'b1, 2'd1, 32'h11}) begin tests_failed++; $display("FAIL multi_grant_beat: got v=%b l=%b s=%0d d=%h want 1 1 1 11", bus.out_valid_o, bus.out_last_o, bus.out_src_o, bus.out_data_o); end
      drop_req(1); drop_req(3);
      @(negedge clk); #1;
      tests_run++; if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL multi_grant_idle: got busy=%b want 0", bus.busy_o); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] exp_data [4];
      bit            rdy_pat  [12];
      int            bi = 0, oi = 0;
      bit            acc = 0, stalled = 0;
      logic [DW-1:0] held = '0;
      exp_data = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
      rdy_pat  = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
      for (int c = 0; c < 30 && oi < 4; c++) begin
         @(negedge clk);
         if (acc) bi++;
         if (bi < 4) set_beat(1, exp_data[bi], 1'(bi == 3)); else drop_req(1);
         bus.out_ready_i = (c < 12) ? rdy_pat[c] : 1'b1;
         if (stalled) begin
            tests_run++; if ({bus.out_valid_o, bus.out_data_o} !== {1'b1, held}) begin tests_failed++; $display("FAIL bp_hold: got v=%b d=%h want 1 %h", bus.out_valid_o, bus.out_data_o, held); end
         end
         if (bus.out_valid_o && bus.out_ready_i) begin
            tests_run++; if ({bus.out_last_o, bus.out_src_o, bus.out_data_o} !== {1'(oi == 3), 2'd1, exp_data[oi]}) begin tests_failed++; $display("FAIL bp_beat%0d: got l=%b s=%0d d=%h want %b 1 %h", oi, bus.out_last_o, bus.out_src_o, bus.out_data_o, oi == 3, exp_data[oi]); end
            $display("[TB] backpressure beat src=%0d data=%h last=%b", bus.out_src_o, bus.out_data_o, bus.out_last_o);
            oi++;
         end
         stalled = bus.out_valid_o && !bus.out_ready_i;
         held    = bus.out_data_o;
         #1 acc = bus.req_ready_o[1];
      end
      tests_run++; if (oi != 4) begin tests_failed++; $display("FAIL bp_count: got %0d beats want 4", oi); end
      drop_req(1); bus.out_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      tests_run++; if ({bus.busy_o, bus.out_valid_o} !== 2'b00) begin tests_failed++; $display("FAIL bp_idle: got busy=%b v=%b want 0 0", bus.busy_o, bus.out_valid_o); end
   endtask

   task automatic test_limit();
      int bi = 0, oi = 0;
      bit acc = 0, saw_rearb = 0, exp_last, exp_rearb;
      for (int c = 0; c < 40 && oi < 6; c++) begin
         @(negedge clk);
         if (acc) bi++;
         if (bi < 6) set_beat(1, 32'hC0 + 32'(bi), 1'(bi == 5)); else drop_req(1);
         bus.out_ready_i = 1'b1;
         if (bus.out_valid_o) begin
`ifdef ARB_BURST_LIMIT_EN
            exp_last = (oi == 3) || (oi == 5);
`else
            exp_last = (oi == 5);
`endif
            tests_run++; if ({bus.out_last_o, bus.out_src_o, bus.out_data_o} !== {exp_last, 2'd1, 32'hC0 + 32'(oi)}) begin tests_failed++; $display("FAIL limit_beat%0d: got l=%b s=%0d d=%h want %b 1 %h", oi, bus.out_last_o, bus.out_src_o, bus.out_data_o, exp_last, 32'hC0 + 32'(oi)); end
            $display("[TB] limit beat src=%0d data=%h last=%b", bus.out_src_o, bus.out_data_o, bus.out_last_o);
            oi++;
         end
         #1;
         if (bi > 0 && bi < 6 && bus.arb_req_o[1]) saw_rearb = 1;
         acc = bus.req_ready_o[1];
      end
      tests_run++; if (oi != 6) begin tests_failed++; $display("FAIL limit_count: got %0d beats want 6", oi); end
`ifdef ARB_BURST_LIMIT_EN
      exp_rearb = 1;
`else
      exp_rearb = 0;
`endif
      tests_run++; if (saw_rearb !== exp_rearb) begin tests_failed++; $display("FAIL limit_rearb: got %b want %b", saw_rearb, exp_rearb); end
      drop_req(1);
      repeat (2) @(negedge clk);
      #1;
      tests_run++; if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL limit_idle: got busy=%b want 0", bus.busy_o); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.out_ready_i = 1'b1; set_beat(2, 32'h50, 1'b0);
      @(negedge clk);
      @(negedge clk);
      set_beat(2, 32'h51, 1'b0);
      @(negedge clk);
      tests_run++; if ({bus.out_valid_o, bus.out_data_o} !== {1'b1, 32'h51}) begin tests_failed++; $display("FAIL rstmid_beat2: got v=%b d=%h want 1 51", bus.out_valid_o, bus.out_data_o); end
      set_beat(2, 32'h52, 1'b0);
      rst_n = 1'b0; #1;
      tests_run++; if ({bus.out_valid_o, bus.out_data_o, bus.busy_o, bus.req_ready_o} !== '0) begin tests_failed++; $display("FAIL rstmid_clear: got v=%b d=%h busy=%b rdy=%b want all 0", bus.out_valid_o, bus.out_data_o, bus.busy_o, bus.req_ready_o); end
      drop_req(2);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      set_beat(0, 32'hF0, 1'b1); #1;
      tests_run++; if ({bus.out_valid_o, bus.arb_req_o} !== 5'b0_0001) begin tests_failed++; $display("FAIL rstmid_req: got v=%b arb=%b want v=0 arb=0001", bus.out_valid_o, bus.arb_req_o); end
      @(negedge clk); #1;
      tests_run++; if (bus.req_ready_o !== 4'b0001) begin tests_failed++; $display("FAIL rstmid_ready: got %b want 0001", bus.req_ready_o); end
      @(negedge clk);
      tests_run++; if ({bus.out_valid_o, bus.out_last_o, bus.out_src_o, bus.out_data_o} !== {1'b1, 1'b1, 2'd0, 32'hF0}) begin tests_failed++; $display("FAIL rstmid_fresh: got v=%b l=%b s=%0d d=%h want 1 1 0 f0", bus.out_valid_o, bus.out_last_o, bus.out_src_o, bus.out_data_o); end
      $display("[TB] post-reset beat src=%0d data=%h last=%b", bus.out_src_o, bus.out_data_o, bus.out_last_o);
      drop_req(0);
      @(negedge clk); #1;
      tests_run++; if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_idle: got busy=%b want 0", bus.busy_o); end
   endtask

   initial begin
      bus.req_valid_i = '0;
      bus.req_data_i  = '0;
      bus.req_last_i  = '0;
      bus.out_ready_i = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_multi_grant();
      test_backpressure();
      test_limit();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
